// File: rtl/instr_encoder.sv
`default_nettype none
// instr_encoder: packs RISC-V fields and an immediate into 32-bit words and streams them
// through a single registered output stage with sequential word addresses and status counters.
module instr_encoder #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            in_opcode,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic                  addr_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_err,
  output logic [15:0]           cnt_ok,
  output logic [15:0]           cnt_err
);

  localparam logic [6:0]  OP_OP     = 7'b0110011;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  localparam logic [2:0] FMT_BAD = 3'd0;
  localparam logic [2:0] FMT_R   = 3'd1;
  localparam logic [2:0] FMT_I   = 3'd2;
  localparam logic [2:0] FMT_S   = 3'd3;
  localparam logic [2:0] FMT_B   = 3'd4;
  localparam logic [2:0] FMT_U   = 3'd5;
  localparam logic [2:0] FMT_J   = 3'd6;

  logic [2:0]            fmt;
  logic [DATA_WIDTH-1:0] hi11, hi12, hi20, hi31;
  logic                  ok_is, ok_b, ok_u, ok_j;
  logic [31:0]           enc_word;
  logic                  enc_err;
  logic                  accept, xfer;

  function automatic logic all_same(input logic [DATA_WIDTH-1:0] v);
    return (&v) | ~(|v);
  endfunction

  always_comb begin
    fmt = FMT_BAD;
    case (in_opcode)
      OP_OP:                     fmt = FMT_R;
      OP_JALR, OP_LOAD, OP_IMM:  fmt = FMT_I;
      OP_STORE:                  fmt = FMT_S;
      OP_BRANCH:                 fmt = FMT_B;
      OP_LUI, OP_AUIPC:          fmt = FMT_U;
      OP_JAL:                    fmt = FMT_J;
      default:                   fmt = FMT_BAD;
    endcase
  end

  // An immediate fits its field when every bit from the field's sign bit upward agrees.
  assign hi11  = DATA_WIDTH'($signed(in_imm) >>> 11);
  assign hi12  = DATA_WIDTH'($signed(in_imm) >>> 12);
  assign hi20  = DATA_WIDTH'($signed(in_imm) >>> 20);
  assign hi31  = DATA_WIDTH'($signed(in_imm) >>> 31);
  assign ok_is = all_same(hi11);
  assign ok_b  = all_same(hi12) && !in_imm[0];
  assign ok_u  = all_same(hi31) && (in_imm[11:0] == 12'd0);
  assign ok_j  = all_same(hi20) && !in_imm[0];

  always_comb begin
    enc_word = NOP_WORD;
    enc_err  = 1'b0;
    case (fmt)
      FMT_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: begin
        if (ok_is) enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        else       enc_err  = 1'b1;
      end
      FMT_S: begin
        if (ok_is) enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        else       enc_err  = 1'b1;
      end
      FMT_B: begin
        if (ok_b) enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], in_opcode};
        else      enc_err  = 1'b1;
      end
      FMT_U: begin
        if (ok_u) enc_word = {in_imm[31:12], in_rd, in_opcode};
        else      enc_err  = 1'b1;
      end
      FMT_J: begin
        if (ok_j) enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        else      enc_err  = 1'b1;
      end
      default: enc_err = 1'b1;
    endcase
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      out_addr  <= BASE_ADDR;
      cnt_ok    <= '0;
      cnt_err   <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_instr <= enc_word;
        out_err   <= enc_err;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end

      // Clear wins over the post-transfer increment, so a held word is re-presented at the base.
      if (addr_clr)  out_addr <= BASE_ADDR;
      else if (xfer) out_addr <= out_addr + ADDR_WIDTH'(4);

      if (xfer) begin
        if (out_err) begin
          if (cnt_err != CNT_MAX) cnt_err <= cnt_err + 16'd1;
        end else begin
          if (cnt_ok != CNT_MAX) cnt_ok <= cnt_ok + 16'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// tb_instr_encoder: directed and randomized checks of instr_encoder against a field-level model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, in_valid, addr_clr, out_ready;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;

  logic        in_ready, out_valid, out_err;
  logic [31:0] out_instr, out_addr;
  logic [15:0] cnt_ok, cnt_err;

  logic        s_in_ready, s_out_valid, s_out_err;
  logic [31:0] s_out_instr;
  logic [3:0]  s_out_addr;
  logic [15:0] s_cnt_ok, s_cnt_err;

  int vectors = 0;
  int miscompares = 0;

  // model state
  logic        m_valid, m_err;
  logic [31:0] m_instr, m_addr;
  logic [15:0] m_cok, m_cerr;
  int          m_saddr;

  always #5 clk = ~clk;

  instr_encoder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(32'd0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .addr_clr(addr_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .out_err(out_err), .cnt_ok(cnt_ok), .cnt_err(cnt_err)
  );

  instr_encoder #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BASE_ADDR(4'd4)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .addr_clr(addr_clr),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr), .out_addr(s_out_addr),
    .out_err(s_out_err), .cnt_ok(s_cnt_ok), .cnt_err(s_cnt_err)
  );

  function automatic void ref_encode(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [31:0] imm, output logic [31:0] w, output logic e);
    longint s;
    s = longint'($signed(imm));
    e = 1'b0;
    w = 32'h0;
    case (op)
      7'b0110011: w = {f7, rs2, rs1, f3, rd, op};
      7'b1100111, 7'b0000011, 7'b0010011: begin
        if (s < -2048 || s > 2047) e = 1'b1;
        else w = {imm[11:0], rs1, f3, rd, op};
      end
      7'b0100011: begin
        if (s < -2048 || s > 2047) e = 1'b1;
        else w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      end
      7'b1100011: begin
        if (s < -4096 || s > 4094 || (s % 2) != 0) e = 1'b1;
        else w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      end
      7'b0110111, 7'b0010111: begin
        if ((imm & 32'hFFF) != 0) e = 1'b1;
        else w = {imm[31:12], rd, op};
      end
      7'b1101111: begin
        if (s < -1048576 || s > 1048574 || (s % 2) != 0) e = 1'b1;
        else w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      end
      default: e = 1'b1;
    endcase
    if (e) w = 32'h0000_0013;
  endfunction

  // Advance one clock and update the transaction-level model from the inputs seen at the edge.
  task automatic tick();
    logic xf, acc;
    xf  = m_valid && out_ready;
    acc = in_valid && (!m_valid || out_ready);
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_err = 1'b0; m_instr = 32'h0; m_addr = 32'h0; m_saddr = 4;
      m_cok = 16'h0; m_cerr = 16'h0;
    end else begin
      if (xf) begin
        if (m_err) begin if (m_cerr != 16'hFFFF) m_cerr = m_cerr + 16'd1; end
        else begin if (m_cok != 16'hFFFF) m_cok = m_cok + 16'd1; end
      end
      if (addr_clr) begin m_addr = 32'h0; m_saddr = 4; end
      else if (xf) begin m_addr = m_addr + 32'd4; m_saddr = (m_saddr + 4) % 16; end
      if (acc) begin
        ref_encode(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, m_instr, m_err);
        m_valid = 1'b1;
      end else if (xf) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm);
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; addr_clr = 1'b0; out_ready = 1'b1;
    drive(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0); in_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
    vectors++; if (out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h want 0", out_instr); end
    vectors++; if (out_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", out_err); end
    vectors++; if (out_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h want 0", out_addr); end
    vectors++; if (s_out_addr !== 4'd4) begin miscompares++; $display("FAIL reset_small_addr got %h want 4", s_out_addr); end
    vectors++; if (cnt_ok !== 16'h0 || cnt_err !== 16'h0) begin miscompares++; $display("FAIL reset_cnt got %h/%h want 0/0", cnt_ok, cnt_err); end
    tick();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL addi_valid got %b want 1", out_valid); end
    vectors++; if (out_instr !== 32'hFFF00093) begin miscompares++; $display("FAIL addi_instr got %h want fff00093", out_instr); end
    vectors++; if (out_addr !== 32'h0 || out_err !== 1'b0) begin miscompares++; $display("FAIL addi_addr_err got %h/%b want 0/0", out_addr, out_err); end
    tick();
    vectors++; if (cnt_ok !== 16'd1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL addi_cnt got %0d valid %b want 1 valid 0", cnt_ok, out_valid); end
  endtask

  task automatic test_back_to_back();
    drive(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    tick();
    drive(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    vectors++; if (out_instr !== 32'h0020A423 || out_addr !== 32'd4) begin miscompares++; $display("FAIL sw got %h@%h want 0020a423@4", out_instr, out_addr); end
    tick();
    in_valid = 1'b0;
    vectors++; if (out_instr !== 32'hFE000EE3 || out_addr !== 32'd8 || out_valid !== 1'b1) begin miscompares++; $display("FAIL beq got %h@%h want fe000ee3@8", out_instr, out_addr); end
    tick();
  endtask

  task automatic test_lui_err();
    drive(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    tick();
    drive(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001);
    vectors++; if (out_instr !== 32'h123452B7 || out_err !== 1'b0) begin miscompares++; $display("FAIL lui got %h err %b want 123452b7 err 0", out_instr, out_err); end
    tick();
    in_valid = 1'b0;
    vectors++; if (out_instr !== 32'h13 || out_err !== 1'b1) begin miscompares++; $display("FAIL lui_bad got %h err %b want 00000013 err 1", out_instr, out_err); end
    tick();
    vectors++; if (cnt_err !== 16'd1) begin miscompares++; $display("FAIL lui_cnt_err got %0d want 1", cnt_err); end
  endtask

  task automatic test_errors();
    logic [31:0] a0;
    a0 = m_addr;
    drive(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    tick();
    drive(7'b0000000, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    vectors++; if (out_instr !== 32'h13 || out_err !== 1'b1 || out_addr !== a0) begin miscompares++; $display("FAIL err_jal got %h err %b @%h want 13 err 1 @%h", out_instr, out_err, out_addr, a0); end
    tick();
    drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    vectors++; if (out_instr !== 32'h13 || out_err !== 1'b1 || out_addr !== a0 + 4) begin miscompares++; $display("FAIL err_op got %h err %b @%h want 13 err 1 @%h", out_instr, out_err, out_addr, a0 + 4); end
    tick();
    in_valid = 1'b0;
    vectors++; if (out_instr !== 32'h13 || out_err !== 1'b1 || out_addr !== a0 + 8) begin miscompares++; $display("FAIL err_imm got %h err %b @%h want 13 err 1 @%h", out_instr, out_err, out_addr, a0 + 8); end
    tick();
    vectors++; if (cnt_err !== 16'd4) begin miscompares++; $display("FAIL err_cnt got %0d want 4", cnt_err); end
  endtask

  task automatic test_backpressure();
    addr_clr = 1'b1; tick(); addr_clr = 1'b0;
    out_ready = 1'b0;
    drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    tick();
    drive(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready cycle %0d got %b want 0", i, in_ready); end
      vectors++; if (out_valid !== 1'b1 || out_instr !== 32'h00100093 || out_addr !== 32'h0) begin miscompares++; $display("FAIL bp_hold cycle %0d got %b %h@%h want 1 00100093@0", i, out_valid, out_instr, out_addr); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    drive(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    vectors++; if (out_instr !== 32'h00200113 || out_addr !== 32'd4) begin miscompares++; $display("FAIL bp_b got %h@%h want 00200113@4", out_instr, out_addr); end
    tick();
    in_valid = 1'b0;
    vectors++; if (out_instr !== 32'h00300193 || out_addr !== 32'd8) begin miscompares++; $display("FAIL bp_c got %h@%h want 00300193@8", out_instr, out_addr); end
    tick();
    vectors++; if (out_valid !== 1'b0 || out_addr !== 32'd12) begin miscompares++; $display("FAIL bp_drain got %b@%h want 0@c", out_valid, out_addr); end
  endtask

  task automatic test_addr_clr();
    out_ready = 1'b1;
    drive(7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
    tick();
    in_valid = 1'b0; addr_clr = 1'b1;
    tick();
    addr_clr = 1'b0;
    vectors++; if (out_addr !== 32'h0) begin miscompares++; $display("FAIL clr_xfer got %h want 0", out_addr); end
    drive(7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    drive(7'b0010011, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
    tick();
    in_valid = 1'b0; out_ready = 1'b0; addr_clr = 1'b1;
    tick();
    addr_clr = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_instr !== 32'h00600313 || out_addr !== 32'h0) begin miscompares++; $display("FAIL clr_held got %b %h@%h want 1 00600313@0", out_valid, out_instr, out_addr); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    addr_clr = 1'b1; tick(); addr_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(7'b0010011, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
      tick();
      vectors++; if (s_out_addr !== 4'(m_saddr) || m_saddr != (4 + 4 * i) % 16) begin miscompares++; $display("FAIL wrap_addr step %0d got %0d want %0d", i, s_out_addr, (4 + 4 * i) % 16); end
      vectors++; if (s_out_instr !== out_instr || s_out_err !== out_err || s_out_valid !== out_valid || s_in_ready !== in_ready) begin miscompares++; $display("FAIL wrap_data step %0d got %h want %h", i, s_out_instr, out_instr); end
    end
    in_valid = 1'b0;
    tick();
    vectors++; if (s_cnt_ok !== cnt_ok || s_cnt_err !== cnt_err) begin miscompares++; $display("FAIL wrap_cnt got %0d/%0d want %0d/%0d", s_cnt_ok, s_cnt_err, cnt_ok, cnt_err); end
  endtask

  task automatic test_random();
    logic [6:0] ops [9] = '{7'b0110011, 7'b1100111, 7'b0000011, 7'b0010011, 7'b0100011,
                            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
    logic [31:0] imm;
    int k;
    for (int c = 0; c < 500; c++) begin
      k = $urandom_range(0, 9);
      case ($urandom_range(0, 4))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: imm = $urandom & 32'hFFFF_F000;
        3: imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
        default: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      endcase
      if ($urandom_range(0, 1) == 1) imm[0] = 1'b0;
      drive(k == 9 ? 7'($urandom) : ops[k], 5'($urandom), 5'($urandom), 5'($urandom),
            3'($urandom), 7'($urandom), imm);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      addr_clr  = ($urandom_range(0, 99) < 3);
      #1;
      vectors++; if (in_ready !== (!m_valid || out_ready)) begin miscompares++; $display("FAIL rnd_in_ready cycle %0d got %b want %b", c, in_ready, !m_valid || out_ready); end
      tick();
      vectors++; if (out_valid !== m_valid || out_addr !== m_addr || s_out_addr !== 4'(m_saddr)) begin miscompares++; $display("FAIL rnd_state cycle %0d got v%b @%h/%h want v%b @%h/%h", c, out_valid, out_addr, s_out_addr, m_valid, m_addr, m_saddr); end
      if (m_valid) begin
        vectors++; if (out_instr !== m_instr || out_err !== m_err) begin miscompares++; $display("FAIL rnd_word cycle %0d got %h err %b want %h err %b", c, out_instr, out_err, m_instr, m_err); end
      end
      vectors++; if (cnt_ok !== m_cok || cnt_err !== m_cerr) begin miscompares++; $display("FAIL rnd_cnt cycle %0d got %0d/%0d want %0d/%0d", c, cnt_ok, cnt_err, m_cok, m_cerr); end
    end
    in_valid = 1'b0; addr_clr = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b0;
    drive(7'b0010011, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    tick();
    in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_err !== 1'b0) begin miscompares++; $display("FAIL rst_mid_out got %b %h %b want 0 0 0", out_valid, out_instr, out_err); end
    vectors++; if (out_addr !== 32'h0 || s_out_addr !== 4'd4) begin miscompares++; $display("FAIL rst_mid_addr got %h/%h want 0/4", out_addr, s_out_addr); end
    vectors++; if (cnt_ok !== 16'h0 || cnt_err !== 16'h0) begin miscompares++; $display("FAIL rst_mid_cnt got %0d/%0d want 0/0", cnt_ok, cnt_err); end
    tick();
    vectors++; if (cnt_ok !== 16'h0) begin miscompares++; $display("FAIL rst_mid_nocount got %0d want 0", cnt_ok); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_lui_err();
    test_errors();
    test_backpressure();
    test_addr_clr();
    test_wrap();
    test_random();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
